dsc_cd_stream_gen: RTL and testbench

Single-clock deterministic stochastic-computing (DSC) bitstream transmitter. It latches NUM_INPUTS binary operands and emits NUM_INPUTS clock-division unary bitstreams in lockstep under a valid/ready handshake. Downstream consumers are the AND-and-count multiplier datapaths and other DSC arithmetic. Counter cascading uses carry enables on one clock, not ripple clocks, so the whole block sits in a single synchronous clock domain.

---
 rtl/dsc_cd_stream_gen.sv | 159 +++++++++++++++
 tb/tb_dsc_cd_stream_gen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dsc_cd_stream_gen.sv
// dsc_cd_stream_gen
//
// Deterministic stochastic-computing bitstream transmitter. It latches NUM_INPUTS
// binary operands and emits one clock-division unary stream per operand, in lockstep,
// under a valid/ready handshake. Stream i is the thermometer code (op[i] > ctr[i]).
// The counters form a carry-enable cascade on the single clock. Stream 0 is the
// fastest and stream NUM_INPUTS-1 the slowest, so every combination of per-stream
// positions appears exactly once in a full frame.
//
// Build option: define DSC_EARLY_TERM_EN to end the frame once the slowest stream
// would stay low for the rest of the frame. The frame is then
// 2^((N-1)*DATA_WIDTH) * op[N-1] beats long. If op[N-1] is 0 the frame has no beats
// and the block goes straight to DONE.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous, active-high reset
//   start        request a new frame; honoured only when idle
//   bin_data_in  operands; operand i sits at [i*DATA_WIDTH +: DATA_WIDTH]
//   busy         high while a frame is running or completing
//   bs_valid     current beat on bs_out is valid
//   bs_ready     consumer accepts the current beat
//   bs_out       one bit per stream for the current beat
//   last         final beat of the frame; qualified by bs_valid
//   done         one-cycle pulse after the final beat transfers

module dsc_cd_stream_gen #(
  parameter int unsigned DATA_WIDTH = 5,
  parameter int unsigned NUM_INPUTS = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] bin_data_in,
  output logic                             busy,
  output logic                             bs_valid,
  input  logic                             bs_ready,
  output logic [NUM_INPUTS-1:0]            bs_out,
  output logic                             last,
  output logic                             done
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam logic [DATA_WIDTH-1:0] CtrMax = '1;
  localparam int unsigned           Top    = NUM_INPUTS - 1;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] op_q  [NUM_INPUTS];
  logic [DATA_WIDTH-1:0] op_d  [NUM_INPUTS];
  logic [DATA_WIDTH-1:0] ctr_q [NUM_INPUTS];
  logic [DATA_WIDTH-1:0] ctr_d [NUM_INPUTS];

  logic                  xfer;
  logic                  low_all_max;
  logic                  last_hit;
  logic                  zero_frame;
  logic [NUM_INPUTS:0]   carry;

  // A beat moves only in RUN, so a stalled consumer freezes every counter.
  assign xfer = (state_q == StRun) & bs_ready;

  // Final-beat decode. Every counter below the slowest one must sit at its maximum.
  always_comb begin
    low_all_max = 1'b1;
    for (int unsigned i = 0; i < Top; i++) begin
      if (ctr_q[i] != CtrMax) begin
        low_all_max = 1'b0;
      end
    end
`ifdef DSC_EARLY_TERM_EN
    // Beyond op[Top]-1 the slowest stream is low for good, so no later beat can
    // add to the AND-count.
    last_hit   = low_all_max & (ctr_q[Top] == (op_q[Top] - DATA_WIDTH'(1)));
    zero_frame = (bin_data_in[Top*DATA_WIDTH +: DATA_WIDTH] == '0);
`else
    last_hit   = low_all_max & (ctr_q[Top] == CtrMax);
    zero_frame = 1'b0;
`endif
  end

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
        op_q[i]  <= '0;
        ctr_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
        op_q[i]  <= op_d[i];
        ctr_q[i] <= ctr_d[i];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = zero_frame ? StDone : StRun;
        end
      end
      StRun: begin
        if (xfer && last_hit) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Operand latch and counter cascade. Counter i advances when every lower counter
  // wraps on this transfer. The wrap after the last beat is harmless because start
  // clears the counters again.
  always_comb begin
    carry[0] = xfer;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      carry[i+1] = carry[i] & (ctr_q[i] == CtrMax);
    end

    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      op_d[i]  = op_q[i];
      ctr_d[i] = carry[i] ? ctr_q[i] + DATA_WIDTH'(1) : ctr_q[i];
    end

    if ((state_q == StIdle) && start) begin
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
        op_d[i]  = bin_data_in[i*DATA_WIDTH +: DATA_WIDTH];
        ctr_d[i] = '0;
      end
    end
  end

  // Output decode. The outputs depend only on registers, never on bs_ready.
  always_comb begin
    busy     = (state_q != StIdle);
    bs_valid = (state_q == StRun);
    done     = (state_q == StDone);
    last     = bs_valid & last_hit;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      bs_out[i] = bs_valid & (op_q[i] > ctr_q[i]);
    end
  end

endmodule

// File: tb/tb_dsc_cd_stream_gen.sv
// Directed bench for dsc_cd_stream_gen at DATA_WIDTH=2, NUM_INPUTS=2.
// Expected frame lengths depend on whether DSC_EARLY_TERM_EN is defined.

module tb_dsc_cd_stream_gen;

  localparam int unsigned DW = 2;
  localparam int unsigned NI = 2;

`ifdef DSC_EARLY_TERM_EN
  localparam int EB23 = 12;  // ops {2,3}: 4 * op1
  localparam int EB11 = 4;   // ops {1,1}
  localparam int EB33 = 12;  // ops {3,3}
  localparam int EB30 = 0;   // ops {3,0}: no beats
`else
  localparam int EB23 = 16;
  localparam int EB11 = 16;
  localparam int EB33 = 16;
  localparam int EB30 = 16;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [NI*DW-1:0] bin_data_in;
  logic             busy;
  logic             bs_valid;
  logic             bs_ready;
  logic [NI-1:0]    bs_out;
  logic             last;
  logic             done;

  int checks = 0;
  int errors = 0;

  dsc_cd_stream_gen #(
    .DATA_WIDTH (DW),
    .NUM_INPUTS (NI)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bin_data_in (bin_data_in),
    .busy        (busy),
    .bs_valid    (bs_valid),
    .bs_ready    (bs_ready),
    .bs_out      (bs_out),
    .last        (last),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge. Starts a frame with the given operands and follows it
  // to completion. Returns at the falling edge of the cycle where busy must be low,
  // which is also the earliest cycle a new start may be accepted.
  task automatic run_frame(input logic [3:0] ops, input bit stall, input bit poke,
                           input int exp_beats, input int exp_pop, input string tag);
    int       beats      = 0;
    int       pop        = 0;
    int       last_beat  = -1;
    int       last_cyc   = -1;
    int       done_cyc   = -1;
    int       viol       = 0;
    int       cyc;
    bit       valid_seen = 1'b0;
    bit       first_vld  = 1'b0;
    bit       prev_stall = 1'b0;
    logic [1:0] prev_out = '0;
    logic       prev_last = 1'b0;

    start       = 1'b1;
    bin_data_in = ops;
    bs_ready    = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    bin_data_in = ~ops;  // must not affect the running frame
    for (cyc = 0; cyc < 200; cyc++) begin
      if (cyc == 0) first_vld = bs_valid;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (bs_valid) valid_seen = 1'b1;
      if (prev_stall && ((bs_out !== prev_out) || (last !== prev_last))) viol++;
      bs_ready = stall ? (cyc % 3 == 0) : 1'b1;
      if (poke) begin
        start       = (cyc == 3);
        bin_data_in = 4'h0;
      end
      if (bs_valid && bs_ready) begin
        beats++;
        if (bs_out === 2'b11) pop++;
        if (last === 1'b1) begin
          last_beat = beats;
          last_cyc  = cyc;
        end
      end
      prev_stall = bs_valid && !bs_ready;
      prev_out   = bs_out;
      prev_last  = last;
      @(negedge clk);
    end
    start    = 1'b0;
    bs_ready = 1'b1;

    check({tag, " first_beat_valid"}, 32'(first_vld), 32'(exp_beats != 0));
    check({tag, " beats"}, beats, exp_beats);
    check({tag, " and_popcount"}, pop, exp_pop);
    check({tag, " done_seen"}, 32'(done_cyc >= 0), 1);
    if (exp_beats != 0) begin
      check({tag, " last_beat"}, last_beat, exp_beats);
      check({tag, " done_cycle"}, done_cyc, last_cyc + 1);
    end else begin
      check({tag, " valid_never"}, 32'(valid_seen), 0);
      check({tag, " done_cycle"}, done_cyc, 0);
    end
    if (stall) check({tag, " stall_stable"}, viol, 0);
    check({tag, " busy_at_done"}, 32'(busy), 1);
    check({tag, " valid_at_done"}, 32'(bs_valid), 0);
    @(negedge clk);
    check({tag, " busy_after"}, 32'(busy), 0);
    check({tag, " done_pulse_1cyc"}, 32'(done), 0);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    bin_data_in = '0;
    bs_ready    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset outputs", {27'd0, busy, bs_valid, last, done, |bs_out}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle busy", 32'(busy), 0);

    // ops {op0=2, op1=3}: AND-count 2*3
    run_frame(4'hE, 1'b0, 1'b0, EB23, 6, "ops23");
    // back-to-back start at the earliest legal cycle; operand 0 at zero and max
    run_frame(4'h3, 1'b0, 1'b0, EB30, 0, "ops30");
    // ops {1,1} with bs_ready pattern 1,0,0,...
    run_frame(4'h5, 1'b1, 1'b0, EB11, 1, "ops11_stall");
    // start pulsed with ops {0,0} mid-frame must be ignored
    run_frame(4'hE, 1'b0, 1'b1, EB23, 6, "ops23_poke");

    // Mid-frame reset at beat 5, then a fresh frame with ops {3,3}
    start       = 1'b1;
    bin_data_in = 4'hE;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre-reset busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midframe reset outputs", {27'd0, busy, bs_valid, last, done, |bs_out}, 0);
    run_frame(4'hF, 1'b0, 1'b0, EB33, 9, "ops33_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so a stuck design still ends the run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
